// File: rtl/calc_operand_entry_if.sv
// Button and operand bus between the operand entry controller and its
// surroundings: raw push-buttons in, registered operands/mode/phase out.
interface calc_operand_entry_if;
   logic       i_btnUp;
   logic       i_btnDown;
   logic       i_btnOp;
   logic       i_btnEnter;
   logic [3:0] o_a;
   logic [3:0] o_b;
   logic       o_mode;
   logic [1:0] o_phase;
   logic       o_resultValid;

   // Stimulus/consumer side: drives the buttons, observes the operands
   modport master (
      output i_btnUp, i_btnDown, i_btnOp, i_btnEnter,
      input  o_a, o_b, o_mode, o_phase, o_resultValid
   );

   // Controller side
   modport slave (
      input  i_btnUp, i_btnDown, i_btnOp, i_btnEnter,
      output o_a, o_b, o_mode, o_phase, o_resultValid
   );
endinterface

// File: rtl/calc_operand_entry.sv
// Push-button operand entry controller for the 4-bit calculator.
// Four raw buttons are synchronised, debounced and edge-detected; the
// resulting one-cycle pulses step a three-phase entry FSM
// (enter A -> enter B -> show result). All outputs are flop outputs.
module calc_operand_entry #(
   parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
   input logic                 i_clk,
   input logic                 i_reset,
   calc_operand_entry_if.slave bus
);

   localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ST_ENTER_A = 2'b00;
   localparam logic [1:0] ST_ENTER_B = 2'b01;
   localparam logic [1:0] ST_RESULT  = 2'b10;

   // Button vector order: 0 = up, 1 = down, 2 = op, 3 = enter
   localparam int unsigned BTN_UP    = 0;
   localparam int unsigned BTN_DOWN  = 1;
   localparam int unsigned BTN_OP    = 2;
   localparam int unsigned BTN_ENTER = 3;

   logic [3:0]    raw;
   logic [3:0]    sync1;
   logic [3:0]    sync2;
   logic [3:0]    db_level;
   logic [3:0]    db_prev;
   logic [3:0]    pulse;
   logic [CW-1:0] db_cnt [4];

   logic [3:0]    a_q;
   logic [3:0]    b_q;
   logic          mode_q;
   logic [1:0]    phase_q;
   logic          valid_q;

   logic          up_p;
   logic          down_p;
   logic          op_p;
   logic          enter_p;

   assign raw = {bus.i_btnEnter, bus.i_btnOp, bus.i_btnDown, bus.i_btnUp};

   // Two-flop synchroniser for every raw button
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   // Debounce: level flips only after the synced input has disagreed with it
   // for DEBOUNCE_CYCLES consecutive cycles
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         db_level <= '0;
         for (int unsigned i = 0; i < 4; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (sync2[i] == db_level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == CNT_LAST) begin
               db_level[i] <= sync2[i];
               db_cnt[i]   <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Rising-edge detect on the debounced levels, registered pulse
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         db_prev <= '0;
         pulse   <= '0;
      end else begin
         db_prev <= db_level;
         pulse   <= db_level & ~db_prev;
      end
   end

   assign up_p    = pulse[BTN_UP];
   assign down_p  = pulse[BTN_DOWN];
   assign op_p    = pulse[BTN_OP];
   assign enter_p = pulse[BTN_ENTER];

   // Entry FSM: enter beats op beats up/down; lower-priority pulses are dropped
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         a_q     <= '0;
         b_q     <= '0;
         mode_q  <= 1'b0;
         phase_q <= ST_ENTER_A;
         valid_q <= 1'b0;
      end else begin
         case (phase_q)
            ST_ENTER_A: begin
               if (enter_p) begin
                  phase_q <= ST_ENTER_B;
               end else if (op_p) begin
                  mode_q <= ~mode_q;
               end else if (up_p && !down_p) begin
                  a_q <= a_q + 4'd1;
               end else if (down_p && !up_p) begin
                  a_q <= a_q - 4'd1;
               end
            end
            ST_ENTER_B: begin
               if (enter_p) begin
                  phase_q <= ST_RESULT;
                  valid_q <= 1'b1;
               end else if (op_p) begin
                  mode_q <= ~mode_q;
               end else if (up_p && !down_p) begin
                  b_q <= b_q + 4'd1;
               end else if (down_p && !up_p) begin
                  b_q <= b_q - 4'd1;
               end
            end
            ST_RESULT: begin
               if (enter_p) begin
                  a_q     <= '0;
                  b_q     <= '0;
                  mode_q  <= 1'b0;
                  valid_q <= 1'b0;
                  phase_q <= ST_ENTER_A;
               end
            end
            default: begin
               a_q     <= '0;
               b_q     <= '0;
               mode_q  <= 1'b0;
               valid_q <= 1'b0;
               phase_q <= ST_ENTER_A;
            end
         endcase
      end
   end

   assign bus.o_a           = a_q;
   assign bus.o_b           = b_q;
   assign bus.o_mode        = mode_q;
   assign bus.o_phase       = phase_q;
   assign bus.o_resultValid = valid_q;

endmodule

// File: tb/tb_calc_operand_entry.sv
// Bench for calc_operand_entry: directed test-plan scenarios plus random
// button traffic, all checked against a behavioural model of the entry rules.
module tb_calc_operand_entry;

   localparam int DB = 4;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   calc_operand_entry_if bus_if ();

   calc_operand_entry #(.DEBOUNCE_CYCLES(DB)) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // Buttons: bit0 up, bit1 down, bit2 op, bit3 enter
   int         m_a, m_b, m_mode, m_phase;
   logic [3:0] m_hist1, m_hist2;   // raw input seen one / two edges ago
   logic [3:0] m_lvl;              // debounced level
   int         m_run [4];          // consecutive disagreeing cycles
   logic [3:0] m_pend1, m_pend2;   // press events waiting to be acted on

   task automatic model_reset();
      m_a = 0; m_b = 0; m_mode = 0; m_phase = 0;
      m_hist1 = '0; m_hist2 = '0; m_lvl = '0;
      m_pend1 = '0; m_pend2 = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
   endtask

   // One clock edge with raw button vector r present at the edge
   task automatic model_step(input logic [3:0] r);
      logic [3:0] act;
      logic [3:0] rise;
      act  = m_pend2;
      rise = '0;
      for (int i = 0; i < 4; i++) begin
         if (m_hist2[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DB) begin
               m_lvl[i] = m_hist2[i];
               m_run[i] = 0;
               if (m_hist2[i]) rise[i] = 1'b1;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_pend2 = m_pend1;
      m_pend1 = rise;
      m_hist2 = m_hist1;
      m_hist1 = r;

      if (act[3]) begin
         if (m_phase == 0) m_phase = 1;
         else if (m_phase == 1) m_phase = 2;
         else begin
            m_a = 0; m_b = 0; m_mode = 0; m_phase = 0;
         end
      end else if (m_phase != 2) begin
         if (act[2]) m_mode = 1 - m_mode;
         else if (act[0] && !act[1]) begin
            if (m_phase == 0) m_a = (m_a + 1) % 16;
            else m_b = (m_b + 1) % 16;
         end else if (act[1] && !act[0]) begin
            if (m_phase == 0) m_a = (m_a + 15) % 16;
            else m_b = (m_b + 15) % 16;
         end
      end
   endtask

   function automatic logic [11:0] pack_model();
      return {m_a[3:0], m_b[3:0], m_mode[0], m_phase[1:0], (m_phase == 2)};
   endfunction

   function automatic logic [11:0] pack_dut();
      return {bus_if.o_a, bus_if.o_b, bus_if.o_mode, bus_if.o_phase, bus_if.o_resultValid};
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- stimulus helpers ----------------
   task automatic tick(input logic [3:0] m);
      @(negedge clk);
      bus_if.i_btnUp    = m[0];
      bus_if.i_btnDown  = m[1];
      bus_if.i_btnOp    = m[2];
      bus_if.i_btnEnter = m[3];
      @(posedge clk);
      model_step(m);
      #1;
      check("cycle", 32'(pack_dut()), 32'(pack_model()));
   endtask

   task automatic press(input logic [3:0] m, input int hold, input int rel);
      for (int i = 0; i < hold; i++) tick(m);
      for (int i = 0; i < rel; i++) tick(4'b0000);
   endtask

   task automatic async_reset();
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_a", 32'(bus_if.o_a), 32'd0);
      check("rst_b", 32'(bus_if.o_b), 32'd0);
      check("rst_mode", 32'(bus_if.o_mode), 32'd0);
      check("rst_phase", 32'(bus_if.o_phase), 32'd0);
      check("rst_valid", 32'(bus_if.o_resultValid), 32'd0);
      model_reset();
      #1 rst = 1'b0;
   endtask

   initial begin
      int a_before;
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      bus_if.i_btnUp = 1'b0; bus_if.i_btnDown = 1'b0;
      bus_if.i_btnOp = 1'b0; bus_if.i_btnEnter = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", 32'(pack_dut()), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // 1. up x3, down x4 with wrap
      repeat (3) press(4'b0001, 10, 10);
      check("p1_a3", 32'(bus_if.o_a), 32'd3);
      check("p1_phase", 32'(bus_if.o_phase), 32'd0);
      repeat (4) press(4'b0010, 10, 10);
      check("p1_wrap", 32'(bus_if.o_a), 32'd15);

      // 2. operand B, mode, result, clear
      press(4'b1000, 10, 10);
      repeat (5) press(4'b0001, 10, 10);
      press(4'b0100, 10, 10);
      press(4'b1000, 10, 10);
      check("p2_b", 32'(bus_if.o_b), 32'd5);
      check("p2_mode", 32'(bus_if.o_mode), 32'd1);
      check("p2_phase", 32'(bus_if.o_phase), 32'd2);
      check("p2_valid", 32'(bus_if.o_resultValid), 32'd1);
      press(4'b0001, 10, 10);
      check("p2_frozen", 32'(bus_if.o_b), 32'd5);
      press(4'b1000, 10, 10);
      check("p2_clear", 32'(pack_dut()), 32'd0);

      // 3. glitch and bounce ignored; held press lands after DB+4 edges
      a_before = int'(bus_if.o_a);
      press(4'b0001, 3, 5);
      press(4'b0001, 2, 2);
      press(4'b0001, 2, 10);
      check("p3_glitch", 32'(bus_if.o_a), 32'(a_before));
      repeat (DB + 3) tick(4'b0001);
      check("p3_early", 32'(bus_if.o_a), 32'(a_before));
      tick(4'b0001);
      check("p3_edge", 32'(bus_if.o_a), 32'((a_before + 1) % 16));
      press(4'b0001, 12, 10);
      check("p3_once", 32'(bus_if.o_a), 32'((a_before + 1) % 16));

      // 4. priority: op over up, enter over up
      a_before = int'(bus_if.o_a);
      press(4'b0101, 10, 10);
      check("p4_op_mode", 32'(bus_if.o_mode), 32'd1);
      check("p4_op_a", 32'(bus_if.o_a), 32'(a_before));
      press(4'b1001, 10, 10);
      check("p4_en_phase", 32'(bus_if.o_phase), 32'd1);
      check("p4_en_a", 32'(bus_if.o_a), 32'(a_before));

      // 5. async reset mid-entry (A=7, B=2, in ENTER_B)
      async_reset();
      repeat (2) tick(4'b0000);
      repeat (7) press(4'b0001, 10, 10);
      press(4'b1000, 10, 10);
      repeat (2) press(4'b0001, 10, 10);
      check("p5_a", 32'(bus_if.o_a), 32'd7);
      check("p5_b", 32'(bus_if.o_b), 32'd2);
      async_reset();
      press(4'b1000, 10, 10);
      check("p5_phase", 32'(bus_if.o_phase), 32'd1);

      // 6. long hold is one increment, re-press is another
      press(4'b0001, 200, 10);
      check("p6_hold", 32'(bus_if.o_b), 32'd1);
      press(4'b0001, 10, 10);
      check("p6_repress", 32'(bus_if.o_b), 32'd2);

      // Random button traffic against the model
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 39) == 0) async_reset();
         press(4'($urandom_range(0, 15)), $urandom_range(1, 12), $urandom_range(1, 12));
      end

      $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
      $finish;
   end

endmodule
